// File: rtl/i2c_cfg_pkg.sv
// Shared definitions for the I2C config arbiter: FSM encoding, frame width
// and the codec device addresses used by the requester ROMs.
package i2c_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  localparam int CFG_FRAME_W = 24;
  localparam int TMO_W       = 10;

  localparam logic [7:0] ES7243E_ADDR = 8'h20;
  localparam logic [7:0] ES8156_ADDR  = 8'h10;

  // Counter/pointer width that stays at least one bit for tiny ranges.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_cfg_arbiter_if.sv
// Bundle between the config sequencers, the arbiter and the I2C byte-write engine.
interface i2c_cfg_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int FRAME_W = i2c_cfg_pkg::CFG_FRAME_W
);
  // Handshakes are levels, not pulses: req[i] stays high with its frame valid
  // until done[i]; eng_start stays high with eng_data stable until eng_tr_end
  // is seen, and a new frame only starts after eng_tr_end has fallen again.
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*FRAME_W-1:0] req_data;
  logic [NUM_REQ-1:0]         gnt;
  logic [NUM_REQ-1:0]         done;
  logic                       done_err;
  logic                       nack_err;
  logic                       timeout_err;
  logic                       busy;
  logic                       eng_start;
  logic [FRAME_W-1:0]         eng_data;
  logic                       eng_tr_end;
  logic                       eng_ack;

  modport slave (
    input  req, req_data, eng_tr_end, eng_ack,
    output gnt, done, done_err, nack_err, timeout_err, busy, eng_start, eng_data
  );

  modport master (
    output req, req_data, eng_tr_end, eng_ack,
    input  gnt, done, done_err, nack_err, timeout_err, busy, eng_start, eng_data
  );
endinterface

// File: rtl/i2c_cfg_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request bit at or after the pointer, wrapping.
module i2c_cfg_arbiter_rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic             o_valid
);

  logic             w_found;
  logic [PTR_W-1:0] w_sel;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < N; k++) begin
      w_sel = PTR_W'((int'(i_ptr) + k) % N);
      if (!w_found && i_req[w_sel]) begin
        o_gnt[w_sel] = 1'b1;
        w_found      = 1'b1;
      end
    end
    o_valid = w_found;
  end

endmodule

// File: rtl/i2c_cfg_arbiter.sv
// Round-robin sharing of one I2C byte-write engine between NUM_REQ config sequencers.
module i2c_cfg_arbiter
  import i2c_cfg_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int FRAME_W    = CFG_FRAME_W,
  parameter int TIMEOUT    = 1023,
  parameter int GAP_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  i2c_cfg_arbiter_if.slave    bus,
  output state_t              o_dbg_state
);

  localparam int PTR_W = min1_clog2(NUM_REQ);
  localparam int GAP_W = min1_clog2(GAP_CYCLES);

  state_t               r_state, w_state;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt;
  logic [PTR_W-1:0]     r_idx, w_idx;
  logic [PTR_W-1:0]     r_ptr, w_ptr;
  logic                 r_eng_start, w_eng_start;
  logic [FRAME_W-1:0]   r_eng_data, w_eng_data;
  logic [TMO_W-1:0]     r_tmo, w_tmo;
  logic [GAP_W-1:0]     r_gap, w_gap;
  logic [NUM_REQ-1:0]   r_done, w_done;
  logic                 r_done_err, w_done_err;
  logic                 r_nack, w_nack;
  logic                 r_tmo_err, w_tmo_err;

  logic [NUM_REQ-1:0]   w_pick_gnt;
  logic                 w_pick_valid;
  logic [PTR_W-1:0]     w_pick_idx;
  logic [FRAME_W-1:0]   w_pick_frame;

  i2c_cfg_arbiter_rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick_gnt),
    .o_valid (w_pick_valid)
  );

  always_comb begin
    w_pick_idx   = '0;
    w_pick_frame = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick_gnt[i]) begin
        w_pick_idx   = PTR_W'(i);
        w_pick_frame = bus.req_data[i*FRAME_W +: FRAME_W];
      end
    end
  end

  always_comb begin
    w_state     = r_state;
    w_gnt       = r_gnt;
    w_idx       = r_idx;
    w_ptr       = r_ptr;
    w_eng_start = r_eng_start;
    w_eng_data  = r_eng_data;
    w_tmo       = r_tmo;
    w_gap       = r_gap;
    w_done      = '0;
    w_done_err  = 1'b0;
    w_nack      = 1'b0;
    w_tmo_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state     = ST_XFER;
          w_gnt       = w_pick_gnt;
          w_idx       = w_pick_idx;
          w_eng_start = 1'b1;
          w_eng_data  = w_pick_frame;
          // The cycle start rises counts as the first one, so start is high
          // for exactly TIMEOUT cycles before the timeout fires.
          w_tmo       = TMO_W'(1);
        end
      end
      ST_XFER: begin
        w_tmo = r_tmo + TMO_W'(1);
        if (bus.eng_tr_end) begin
          w_eng_start = 1'b0;
          w_done      = r_gnt;
          w_done_err  = bus.eng_ack;
          w_nack      = bus.eng_ack;
          w_state     = ST_RELEASE;
        end else if (r_tmo == TMO_W'(TIMEOUT)) begin
          w_eng_start = 1'b0;
          w_done      = r_gnt;
          w_done_err  = 1'b1;
          w_tmo_err   = 1'b1;
          w_state     = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        w_gnt = '0;
        w_tmo = '0;
        w_ptr = (r_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_idx + PTR_W'(1);
        // Hold here while the engine still shows the old tr_end.
        if (!bus.eng_tr_end) begin
          w_gap   = '0;
          w_state = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_gap == GAP_W'(GAP_CYCLES - 1)) w_state = ST_IDLE;
        else                                 w_gap   = r_gap + GAP_W'(1);
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_idx       <= '0;
      r_ptr       <= '0;
      r_eng_start <= 1'b0;
      r_eng_data  <= '0;
      r_tmo       <= '0;
      r_gap       <= '0;
      r_done      <= '0;
      r_done_err  <= 1'b0;
      r_nack      <= 1'b0;
      r_tmo_err   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_gnt       <= w_gnt;
      r_idx       <= w_idx;
      r_ptr       <= w_ptr;
      r_eng_start <= w_eng_start;
      r_eng_data  <= w_eng_data;
      r_tmo       <= w_tmo;
      r_gap       <= w_gap;
      r_done      <= w_done;
      r_done_err  <= w_done_err;
      r_nack      <= w_nack;
      r_tmo_err   <= w_tmo_err;
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.done        = r_done;
  assign bus.done_err    = r_done_err;
  assign bus.nack_err    = r_nack;
  assign bus.timeout_err = r_tmo_err;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.eng_start   = r_eng_start;
  assign bus.eng_data    = r_eng_data;
  assign o_dbg_state     = r_state;

endmodule
